// File: rtl/ddr_app_pkg.sv
// Shared types and constants for the DDR application-port arbiter.
package ddr_app_pkg;

    localparam int unsigned ADX_W   = 27;
    localparam int unsigned BEAT_W  = 64;
    localparam int unsigned BURST_W = 128;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [2:0] {
        StIdle,
        StRdCmd,
        StWrData1,
        StWrData2,
        StWrCmd
    } arb_state_e;

    typedef enum logic {
        KindRead  = 1'b0,
        KindWrite = 1'b1
    } req_kind_e;

endpackage

// File: rtl/ddr_grant_sel.sv
// Read/write grant selection with a bounded run length for same-kind grants.
module ddr_grant_sel
    import ddr_app_pkg::*;
#(
    parameter int unsigned SAME_KIND_LIMIT = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      grant_en,
    input  logic      has_rd,
    input  logic      has_wr,
    output req_kind_e grant_kind
);

    localparam int unsigned CW = $clog2(SAME_KIND_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(SAME_KIND_LIMIT);

    req_kind_e      last_kind_q;
    logic [CW-1:0]  consec_q;

    // Pick the kind to grant; on a tie stay with the last kind until its run hits the limit.
    always_comb begin
        grant_kind = KindRead;
        if (has_rd && !has_wr) begin
            grant_kind = KindRead;
        end else if (has_wr && !has_rd) begin
            grant_kind = KindWrite;
        end else if (consec_q < LIMIT) begin
            grant_kind = last_kind_q;
        end else begin
            grant_kind = (last_kind_q == KindRead) ? KindWrite : KindRead;
        end
    end

    // Track the kind of the last grant and how many of that kind ran back to back.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_kind_q <= KindRead;
            consec_q    <= '0;
        end else if (grant_en) begin
            last_kind_q <= grant_kind;
            if (grant_kind == last_kind_q) begin
                consec_q <= (consec_q == LIMIT) ? consec_q : consec_q + 1'b1;
            end else begin
                consec_q <= CW'(1);
            end
        end
    end

endmodule

// File: rtl/ddr_app_arbiter.sv
// Arbitrates a read-address FIFO and a write-request FIFO onto a DDR controller app port.
module ddr_app_arbiter
    import ddr_app_pkg::*;
#(
    parameter int unsigned SAME_KIND_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init_calib_complete,
    input  logic               f2a_has_rd_req,
    input  logic [ADX_W-1:0]   f2a_app_adx,
    output logic               f2a_get_rd_adr,
    input  logic               w2a_has_wr_req,
    input  logic [ADX_W-1:0]   w2a_wr_adx,
    input  logic [BURST_W-1:0] w2a_wr_data,
    output logic               w2a_get_wr_req,
    output logic               app_en,
    output logic [2:0]         app_cmd,
    output logic [ADX_W-1:0]   app_addr,
    input  logic               app_rdy,
    output logic [BEAT_W-1:0]  app_wdf_data,
    output logic               app_wdf_wren,
    output logic               app_wdf_end,
    input  logic               app_wdf_rdy,
    output logic               arb_busy
);

    arb_state_e          state_q, state_d;
    logic [ADX_W-1:0]    addr_q;
    logic [BURST_W-1:0]  data_q;
    // Last driven values, so command/address/data hold steady when not being driven.
    logic [2:0]          cmd_hold_q;
    logic [ADX_W-1:0]    addr_hold_q;
    logic [BEAT_W-1:0]   wdf_hold_q;
    logic                grant_en;
    req_kind_e           grant_kind;

    // Reset is folded in so nothing is popped while reset is asserted.
    assign grant_en = (state_q == StIdle) && init_calib_complete && !reset &&
                      (f2a_has_rd_req || w2a_has_wr_req);
    assign arb_busy = (state_q != StIdle);

    ddr_grant_sel #(
        .SAME_KIND_LIMIT(SAME_KIND_LIMIT)
    ) u_grant_sel (
        .clk       (clk),
        .reset     (reset),
        .grant_en  (grant_en),
        .has_rd    (f2a_has_rd_req),
        .has_wr    (w2a_has_wr_req),
        .grant_kind(grant_kind)
    );

    // Next-state and output decode; outputs default to idle/hold values.
    always_comb begin
        state_d        = state_q;
        f2a_get_rd_adr = 1'b0;
        w2a_get_wr_req = 1'b0;
        app_en         = 1'b0;
        app_cmd        = cmd_hold_q;
        app_addr       = addr_hold_q;
        app_wdf_data   = wdf_hold_q;
        app_wdf_wren   = 1'b0;
        app_wdf_end    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_en) begin
                    if (grant_kind == KindRead) begin
                        f2a_get_rd_adr = 1'b1;
                        state_d        = StRdCmd;
                    end else begin
                        w2a_get_wr_req = 1'b1;
                        state_d        = StWrData1;
                    end
                end
            end
            StRdCmd: begin
                app_en   = 1'b1;
                app_cmd  = CMD_RD;
                app_addr = addr_q;
                if (app_rdy) state_d = StIdle;
            end
            StWrData1: begin
                app_wdf_wren = 1'b1;
                app_wdf_data = data_q[BEAT_W-1:0];
                if (app_wdf_rdy) state_d = StWrData2;
            end
            StWrData2: begin
                app_wdf_wren = 1'b1;
                app_wdf_end  = 1'b1;
                app_wdf_data = data_q[BURST_W-1:BEAT_W];
                if (app_wdf_rdy) state_d = StWrCmd;
            end
            StWrCmd: begin
                app_en   = 1'b1;
                app_cmd  = CMD_WR;
                app_addr = addr_q;
                if (app_rdy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, captured request and last-driven output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            data_q      <= '0;
            cmd_hold_q  <= '0;
            addr_hold_q <= '0;
            wdf_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_hold_q  <= app_cmd;
            addr_hold_q <= app_addr;
            wdf_hold_q  <= app_wdf_data;
            if (f2a_get_rd_adr) begin
                addr_q <= f2a_app_adx;
            end else if (w2a_get_wr_req) begin
                addr_q <= w2a_wr_adx;
                data_q <= w2a_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_ddr_app_arbiter.sv
// Directed self-checking bench for ddr_app_arbiter.
module tb_ddr_app_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         init_calib_complete;
    logic         f2a_has_rd_req;
    logic [26:0]  f2a_app_adx;
    logic         f2a_get_rd_adr;
    logic         w2a_has_wr_req;
    logic [26:0]  w2a_wr_adx;
    logic [127:0] w2a_wr_data;
    logic         w2a_get_wr_req;
    logic         app_en;
    logic [2:0]   app_cmd;
    logic [26:0]  app_addr;
    logic         app_rdy;
    logic [63:0]  app_wdf_data;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic         arb_busy;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] LO = 64'h5555_5555_5555_5555;
    localparam logic [63:0] HI = 64'hAAAA_AAAA_AAAA_AAAA;

    ddr_app_arbiter #(
        .SAME_KIND_LIMIT(4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .init_calib_complete(init_calib_complete),
        .f2a_has_rd_req     (f2a_has_rd_req),
        .f2a_app_adx        (f2a_app_adx),
        .f2a_get_rd_adr     (f2a_get_rd_adr),
        .w2a_has_wr_req     (w2a_has_wr_req),
        .w2a_wr_adx         (w2a_wr_adx),
        .w2a_wr_data        (w2a_wr_data),
        .w2a_get_wr_req     (w2a_get_wr_req),
        .app_en             (app_en),
        .app_cmd            (app_cmd),
        .app_addr           (app_addr),
        .app_rdy            (app_rdy),
        .app_wdf_data       (app_wdf_data),
        .app_wdf_wren       (app_wdf_wren),
        .app_wdf_end        (app_wdf_end),
        .app_wdf_rdy        (app_wdf_rdy),
        .arb_busy           (arb_busy)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        init_calib_complete = 1'b0;
        f2a_has_rd_req      = 1'b0;
        f2a_app_adx         = '0;
        w2a_has_wr_req      = 1'b0;
        w2a_wr_adx          = '0;
        w2a_wr_data         = '0;
        app_rdy             = 1'b0;
        app_wdf_rdy         = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        // Requests pending during reset must not be popped.
        init_calib_complete = 1'b1;
        f2a_has_rd_req      = 1'b1;
        w2a_has_wr_req      = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if ({app_en, app_wdf_wren, app_wdf_end, arb_busy} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got en=%b wren=%b end=%b busy=%b want 0000",
                     app_en, app_wdf_wren, app_wdf_end, arb_busy);
        end
        checks++;
        if (app_cmd !== 3'd0 || app_addr !== 27'd0 || app_wdf_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_data got cmd=%h addr=%h wdf=%h want all 0",
                     app_cmd, app_addr, app_wdf_data);
        end
        checks++;
        if (f2a_get_rd_adr !== 1'b0 || w2a_get_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_gets got rd=%b wr=%b want 0 0",
                     f2a_get_rd_adr, w2a_get_wr_req);
        end
    endtask

    task automatic test_calib_gate();
        int pulses;
        int en_seen;
        reset_dut();
        f2a_has_rd_req = 1'b1;
        w2a_has_wr_req = 1'b1;
        f2a_app_adx    = 27'h0000777;
        w2a_wr_adx     = 27'h0000888;
        pulses  = 0;
        en_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pulses  += int'(f2a_get_rd_adr) + int'(w2a_get_wr_req);
            en_seen += int'(app_en) + int'(arb_busy);
            step();
        end
        checks++;
        if (pulses != 0 || en_seen != 0) begin
            errors++;
            $display("FAIL calib_block got pulses=%0d en_busy=%0d want 0 0", pulses, en_seen);
        end
        init_calib_complete = 1'b1;
        @(negedge clk);
        checks++;
        if (f2a_get_rd_adr !== 1'b1 || w2a_get_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL calib_first got rd=%b wr=%b want 1 0",
                     f2a_get_rd_adr, w2a_get_wr_req);
        end
        step();
        f2a_has_rd_req = 1'b0;
        w2a_has_wr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (app_en !== 1'b1 || app_cmd !== 3'b001 || app_addr !== 27'h0000777) begin
            errors++;
            $display("FAIL calib_rdcmd got en=%b cmd=%b addr=%h want 1 001 0000777",
                     app_en, app_cmd, app_addr);
        end
    endtask

    task automatic test_read_backpressure();
        int pulses;
        int en_good;
        reset_dut();
        init_calib_complete = 1'b1;
        f2a_has_rd_req      = 1'b1;
        f2a_app_adx         = 27'h0000123;
        @(negedge clk);
        pulses = int'(f2a_get_rd_adr);
        step();
        f2a_has_rd_req = 1'b0;
        en_good = 0;
        for (int i = 0; i < 6; i++) begin
            app_rdy = (i == 5);
            @(negedge clk);
            pulses += int'(f2a_get_rd_adr);
            if (app_en === 1'b1 && app_cmd === 3'b001 && app_addr === 27'h0000123 &&
                arb_busy === 1'b1)
                en_good++;
            step();
        end
        app_rdy = 1'b0;
        checks++;
        if (en_good != 6) begin
            errors++;
            $display("FAIL rd_hold got %0d good cycles want 6", en_good);
        end
        @(negedge clk);
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL rd_pops got %0d want 1", pulses);
        end
        checks++;
        if (app_en !== 1'b0 || arb_busy !== 1'b0 || app_addr !== 27'h0000123 ||
            app_cmd !== 3'b001) begin
            errors++;
            $display("FAIL rd_after got en=%b busy=%b addr=%h cmd=%b want 0 0 0000123 001",
                     app_en, arb_busy, app_addr, app_cmd);
        end
    endtask

    task automatic test_write_order();
        reset_dut();
        init_calib_complete = 1'b1;
        w2a_has_wr_req      = 1'b1;
        w2a_wr_adx          = 27'h0000456;
        w2a_wr_data         = {HI, LO};
        @(negedge clk);
        checks++;
        if (w2a_get_wr_req !== 1'b1 || f2a_get_rd_adr !== 1'b0) begin
            errors++;
            $display("FAIL wr_grant got wr=%b rd=%b want 1 0", w2a_get_wr_req, f2a_get_rd_adr);
        end
        step();
        w2a_has_wr_req = 1'b0;
        // Each beat is seen once stalled and once accepted.
        for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < 2; s++) begin
                app_wdf_rdy = (s == 1);
                @(negedge clk);
                checks++;
                if (app_wdf_wren !== 1'b1 || app_en !== 1'b0 ||
                    app_wdf_end !== (b == 1) || app_wdf_data !== ((b == 0) ? LO : HI)) begin
                    errors++;
                    $display("FAIL wr_beat%0d got wren=%b en=%b end=%b data=%h", b + 1,
                             app_wdf_wren, app_en, app_wdf_end, app_wdf_data);
                end
                step();
            end
        end
        app_wdf_rdy = 1'b0;
        app_rdy     = 1'b1;
        @(negedge clk);
        checks++;
        if (app_en !== 1'b1 || app_cmd !== 3'b000 || app_addr !== 27'h0000456 ||
            app_wdf_wren !== 1'b0 || app_wdf_data !== HI) begin
            errors++;
            $display("FAIL wr_cmd got en=%b cmd=%b addr=%h wren=%b data=%h",
                     app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_data);
        end
        step();
        app_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (app_en !== 1'b0 || arb_busy !== 1'b0 || app_cmd !== 3'b000) begin
            errors++;
            $display("FAIL wr_done got en=%b busy=%b cmd=%b want 0 0 000",
                     app_en, arb_busy, app_cmd);
        end
    endtask

    task automatic test_fairness();
        int   exp_cyc [10];
        logic exp_wr  [10];
        int   n;
        exp_cyc = '{0, 2, 4, 6, 8, 12, 16, 20, 24, 26};
        exp_wr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        reset_dut();
        init_calib_complete = 1'b1;
        f2a_has_rd_req      = 1'b1;
        w2a_has_wr_req      = 1'b1;
        app_rdy             = 1'b1;
        app_wdf_rdy         = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
            @(negedge clk);
            if (f2a_get_rd_adr === 1'b1 || w2a_get_wr_req === 1'b1) begin
                checks++;
                if (w2a_get_wr_req !== exp_wr[n] || f2a_get_rd_adr !== !exp_wr[n] ||
                    cyc != exp_cyc[n]) begin
                    errors++;
                    $display("FAIL fair_grant%0d got wr=%b rd=%b cyc=%0d want wr=%b cyc=%0d",
                             n, w2a_get_wr_req, f2a_get_rd_adr, cyc, exp_wr[n], exp_cyc[n]);
                end
                n++;
            end
            step();
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL fair_count got %0d grants want 10", n);
        end
    endtask

    task automatic test_reset_mid_write();
        reset_dut();
        init_calib_complete = 1'b1;
        w2a_has_wr_req      = 1'b1;
        w2a_wr_data         = {HI, LO};
        w2a_wr_adx          = 27'h0000321;
        app_wdf_rdy         = 1'b1;
        step();
        w2a_has_wr_req = 1'b0;
        step();
        app_wdf_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup got wren=%b end=%b want 1 1", app_wdf_wren, app_wdf_end);
        end
        step();
        reset          = 1'b1;
        f2a_has_rd_req = 1'b1;
        w2a_has_wr_req = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if ({app_en, app_wdf_wren, app_wdf_end, arb_busy, f2a_get_rd_adr,
             w2a_get_wr_req} !== 6'b0 || app_wdf_data !== 64'd0 || app_addr !== 27'd0) begin
            errors++;
            $display("FAIL mid_reset got en=%b wren=%b end=%b busy=%b data=%h addr=%h",
                     app_en, app_wdf_wren, app_wdf_end, arb_busy, app_wdf_data, app_addr);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (f2a_get_rd_adr !== 1'b1 || w2a_get_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_tie got rd=%b wr=%b want 1 0", f2a_get_rd_adr, w2a_get_wr_req);
        end
    endtask

    initial begin
        test_reset();
        test_calib_gate();
        test_read_backpressure();
        test_write_order();
        test_fairness();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_app_arbiter.md
DDR_APP_ARBITER -- requirements
Module: ddr_app_arbiter

Interface
REQ-001 SHALL have parameter SAME_KIND_LIMIT, default 4, max consecutive same-kind grants while the other kind is pending.
REQ-002 SHALL have ports: clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: init_calib_complete  in  1  controller calibration done; no commands issued while low.
REQ-005 SHALL have ports: f2a_has_rd_req  in  1, f2a_app_adx  in  27, f2a_get_rd_adr  out  1  (read-address FIFO; dout valid while has_rd_req high).
REQ-006 SHALL have ports: w2a_has_wr_req  in  1, w2a_wr_adx  in  27, w2a_wr_data  in  128, w2a_get_wr_req  out  1  (write-request FIFO; dout valid while has_wr_req high).
REQ-007 SHALL have ports: app_en  out  1, app_cmd  out  3, app_addr  out  27, app_rdy  in  1  (controller command port).
REQ-008 SHALL have ports: app_wdf_data  out  64, app_wdf_wren  out  1, app_wdf_end  out  1, app_wdf_rdy  in  1  (controller write-data port).
REQ-009 SHALL have ports: arb_busy  out  1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, RD_CMD, WR_DATA1, WR_DATA2, WR_CMD.
REQ-011 IDLE: grant SHALL occur only when init_calib_complete is high and at least one request is pending; otherwise remain in IDLE.
REQ-012 Grant rule: if only one kind is pending, grant it; if both are pending, grant last_kind when consec < SAME_KIND_LIMIT, otherwise grant the other kind.
REQ-013 consec SHALL increment (saturating at SAME_KIND_LIMIT) on a same-kind grant, load 1 on a kind switch, and update last_kind on every grant.
REQ-014 Read grant: pulse f2a_get_rd_adr for exactly one cycle in the IDLE grant cycle, capture f2a_app_adx into addr_q, and go to RD_CMD next cycle.
REQ-015 Write grant: pulse w2a_get_wr_req for exactly one cycle in the IDLE grant cycle, capture address into addr_q and data into data_q, and go to WR_DATA1.
REQ-016 RD_CMD: app_en=1, app_cmd=3'b001, app_addr=addr_q; go to IDLE on the cycle app_rdy=1, otherwise hold.
REQ-017 WR_DATA1: app_wdf_wren=1, app_wdf_data=data_q[63:0], app_wdf_end=0; advance to WR_DATA2 when app_wdf_rdy=1.
REQ-018 WR_DATA2: app_wdf_wren=1, app_wdf_data=data_q[127:64], app_wdf_end=1; advance to WR_CMD when app_wdf_rdy=1.
REQ-019 WR_CMD: app_en=1, app_cmd=3'b000, app_addr=addr_q; go to IDLE when app_rdy=1.
REQ-020 Outside the named states: app_en=0, app_wdf_wren=0, app_wdf_end=0; app_cmd, app_addr and app_wdf_data SHALL hold their last values.
REQ-021 Minimum spacing: one command per 2 cycles for reads and one per 4 cycles for writes; no grant occurs in the cycle a command is accepted.
REQ-022 app_en and app_wdf_wren SHALL be held stable until accepted and SHALL never be withdrawn, except by reset.
REQ-023 init_calib_complete falling mid-operation SHALL NOT abort the transaction in progress; it blocks only new grants.
REQ-024 A request present with both has-flags toggling the same cycle SHALL be sampled only in IDLE; requests are never popped outside IDLE.

Reset
REQ-025 On reset: state=IDLE, last_kind=READ, consec=0, addr_q=0, data_q=0, and all outputs 0, effective at the next rising edge.
REQ-026 Reset mid-transaction SHALL drop app_en and app_wdf_wren at the next edge; the already-popped request is discarded.
REQ-027 The first tie after reset SHALL grant READ.

Structure
REQ-028 Shared package ddr_app_pkg SHALL hold the command encodings (CMD_WR=3'b000, CMD_RD=3'b001), the state encoding, and the width constants ADX_W=27, BEAT_W=64, BURST_W=128.
REQ-029 Grant selection (REQ-012/013) SHALL be a sub-module ddr_grant_sel; the FSM and datapath remain in ddr_app_arbiter.

Verification
REQ-030 Calibration gating: calib=0 with both requests pending for 20 cycles -> no get pulses and app_en=0; calib=1 -> read granted first.
REQ-031 Read backpressure: single read adx=27'h0000123 with app_rdy low for 5 cycles -> app_en held 6 cycles with addr 0x123 and cmd 001; exactly one f2a_get_rd_adr pulse.
REQ-032 Write beat order: data=128'hAAAA..._5555... -> beat1 0x5555... with end=0, beat2 0xAAAA... with end=1, then cmd 000; one stall on app_wdf_rdy per beat is tolerated.
REQ-033 Fairness: both FIFOs continuously non-empty with LIMIT=4 -> grant sequence R,R,R,R,W,W,W,W,R,...
REQ-034 Reset mid-WR_DATA2 -> next cycle all outputs 0 and state IDLE; next tie grants READ.
